conv_read_controller: RTL and testbench

CONV_READ_CONTROLLER -- requirements
Module: conv_read_controller

---
 rtl/conv_ctrl_pkg.sv | 20 ++
 rtl/conv_marker_delay.sv | 36 +++
 rtl/conv_read_controller.sv | 148 ++++++++++++++
 tb/tb_conv_read_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution read controller: FSM state encoding,
// default MAC pipeline latency and a counter-width helper.
package conv_ctrl_pkg;

    localparam int DEFAULT_PIPE_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_marker_delay.sv
// Stallable delay line carrying {window-start, window-end} markers alongside
// the MAC pipeline so they emerge aligned with the matching product.
module conv_marker_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [DEPTH-1:0][1:0] stage_q;
    logic [DEPTH-1:0][1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_read_controller.sv
// Read controller for one convolution pass: clears the address generator, issues
// reads, aligns accumulator clear / OFMap write with the MAC output and drains.
// Define CONV_CTRL_PERF_EN to add saturating stall/busy performance counters.
module conv_read_controller
    import conv_ctrl_pkg::*;
#(
    parameter int PIPE_LATENCY = DEFAULT_PIPE_LATENCY,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic window_ready,
    input  logic ofmap_full,
    input  logic co_pipe,
    input  logic at_end_data,
    output logic clr_addr,
    output logic read_data,
    output logic stall,
    output logic valid_end,
    output logic acc_clr,
    output logic ofmap_wen,
    output logic busy,
    output logic done
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] busy_cycles
`endif
);

    localparam int DW = cnt_bits(PIPE_LATENCY);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);

    ctrl_state_e   state_q, state_d;
    logic          first_q, first_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          issue, win_end, win_start;
    logic [1:0]    marker_out;

    assign clr_addr  = (state_q == ST_CLEAR);
    assign read_data = (state_q == ST_READ);
    assign busy      = (state_q == ST_CLEAR) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign valid_end = read_data & window_ready;
    assign stall     = ((state_q == ST_READ) || (state_q == ST_DRAIN)) &
                       (ofmap_full | (read_data & ~window_ready));

    assign issue     = read_data & ~stall;
    assign win_end   = issue & co_pipe;
    assign win_start = issue & first_q;

    // first_q flags that the next issue opens a new window.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        drain_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                first_d = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                if (issue) first_d = co_pipe;
                if (win_end && at_end_data) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q;
                if (!stall) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    conv_marker_delay #(
        .DEPTH (PIPE_LATENCY)
    ) u_marker_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (~stall),
        .din  ({win_start, win_end}),
        .dout (marker_out)
    );

    // A write held back by a stall stays in the last stage and fires once it clears.
    assign acc_clr   = marker_out[1];
    assign ofmap_wen = marker_out[0] & ~stall;

`ifdef CONV_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] busy_cnt_q, busy_cnt_d;

    // CLEAR restarts both counters and is itself the first busy cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        if (state_q == ST_CLEAR) begin
            stall_cnt_d = '0;
            busy_cnt_d  = CNT_WIDTH'(1);
        end else begin
            if (busy && !(&busy_cnt_q)) busy_cnt_d = busy_cnt_q + CNT_WIDTH'(1);
            if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign busy_cycles  = busy_cnt_q;
`else
    localparam int cnt_width_unused = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_conv_read_controller.sv
// Directed self-checking bench for conv_read_controller with a scoreboard of
// expected acc_clr / ofmap_wen cycles; counter checks follow CONV_CTRL_PERF_EN.
module tb_conv_read_controller;

    localparam int FS = 3;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst, start, window_ready, ofmap_full, co_pipe, at_end_data;
    logic clr_addr, read_data, stall, valid_end, acc_clr, ofmap_wen, busy, done;
`ifdef CONV_CTRL_PERF_EN
    logic [15:0] stall_cycles, busy_cycles;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wen_cnt = 0;
    int clr_cnt = 0;
    int iss, nwin;
    logic wstart, last;
    int wen_q[$];
    int clr_q[$];

    conv_read_controller #(
        .PIPE_LATENCY (PL),
        .CNT_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .window_ready (window_ready),
        .ofmap_full   (ofmap_full),
        .co_pipe      (co_pipe),
        .at_end_data  (at_end_data),
        .clr_addr     (clr_addr),
        .read_data    (read_data),
        .stall        (stall),
        .valid_end    (valid_end),
        .acc_clr      (acc_clr),
        .ofmap_wen    (ofmap_wen),
        .busy         (busy),
        .done         (done)
`ifdef CONV_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .busy_cycles  (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every acc_clr / ofmap_wen pulse must match the next expected cycle.
    always @(negedge clk) begin : monitor
        int want;
        if (rst === 1'b1) begin
            if (ofmap_wen === 1'b1) begin
                wen_cnt++;
                want = (wen_q.size() > 0) ? wen_q.pop_front() : -1;
                check("ofmap_wen_cycle", cyc, want);
            end
            if (acc_clr === 1'b1) begin
                clr_cnt++;
                want = (clr_q.size() > 0) ? clr_q.pop_front() : -1;
                check("acc_clr_cycle", cyc, want);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    // A stalled cycle holds every marker still in flight for one more cycle.
    task automatic shift_expect();
        foreach (wen_q[i]) if (wen_q[i] >= cyc) wen_q[i]++;
        foreach (clr_q[i]) if (clr_q[i] > cyc) clr_q[i]++;
    endtask

    task automatic do_start();
        iss = 0;
        wstart = 1'b1;
        last = 1'b0;
        start = 1'b1;
        ofmap_full = 1'b1;
        window_ready = 1'b1;
        co_pipe = 1'b0;
        at_end_data = 1'b0;
        @(negedge clk);
        check("idle_stall_with_start", stall, 0);
        check("idle_busy", busy, 0);
        tick();
        start = 1'b0;
        ofmap_full = 1'b0;
        @(negedge clk);
        check("clear_clr_addr", clr_addr, 1);
        check("clear_busy", busy, 1);
        check("clear_read_data", read_data, 0);
        tick();
    endtask

    task automatic cycle_read(input logic wr, input logic full, input logic st);
        logic exp_stall;
        start = st;
        window_ready = wr;
        ofmap_full = full;
        co_pipe = ((iss % FS) == FS - 1);
        at_end_data = ((iss / FS) == nwin - 1);
        exp_stall = full | ~wr;
        if (exp_stall) shift_expect();
        @(negedge clk);
        check("read_data", read_data, 1);
        check("read_stall", stall, exp_stall);
        check("valid_end", valid_end, wr);
        if (!exp_stall) begin
            if (wstart) clr_q.push_back(cyc + PL);
            if (co_pipe) wen_q.push_back(cyc + PL);
            last = co_pipe & at_end_data;
            wstart = co_pipe;
            iss++;
        end
        tick();
    endtask

    task automatic run_read(input int nw, input int ev_at, input int ev_len, input bit ev_full, input int st_at);
        bit ev;
        nwin = nw;
        for (int g = 0; g < 60 && !last; g++) begin
            ev = (g >= ev_at) && (g < ev_at + ev_len);
            cycle_read(!(ev && !ev_full), ev && ev_full, g == st_at);
        end
        start = 1'b0;
        check("read_phase_ended", last, 1);
    endtask

    task automatic cycle_drain(input logic full);
        start = 1'b0;
        ofmap_full = full;
        window_ready = 1'b1;
        co_pipe = 1'b0;
        at_end_data = 1'b0;
        if (full) shift_expect();
        @(negedge clk);
        check("drain_busy", busy, 1);
        check("drain_read_data", read_data, 0);
        check("drain_stall", stall, full);
        check("drain_valid_end", valid_end, 0);
        tick();
    endtask

    task automatic finish_pass(input int drain_stalls);
        int ns;
        logic f;
        ns = 0;
        for (int g = 0; g < 20 && ns < PL; g++) begin
            f = (g < drain_stalls);
            cycle_drain(f);
            if (!f) ns++;
        end
        ofmap_full = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        tick();
        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_busy_low", busy, 0);
        tick();
    endtask

    task automatic full_pass(input string tag, input int nw, input int ev_at, input int ev_len,
                             input bit ev_full, input int st_at, input int drain_stalls);
        int d0, w0, c0;
        d0 = done_cnt;
        w0 = wen_cnt;
        c0 = clr_cnt;
        do_start();
        run_read(nw, ev_at, ev_len, ev_full, st_at);
        finish_pass(drain_stalls);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_wen_count"}, wen_cnt - w0, nw);
        check({tag, "_acc_clr_count"}, clr_cnt - c0, nw);
        check({tag, "_wen_pending"}, wen_q.size(), 0);
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        start = 1'b0;
        window_ready = 1'b0;
        ofmap_full = 1'b0;
        co_pipe = 1'b0;
        at_end_data = 1'b0;
        #1;
        check("reset_outputs", {clr_addr, read_data, stall, valid_end, acc_clr, ofmap_wen, busy, done}, 0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", {clr_addr, read_data, stall, valid_end, acc_clr, ofmap_wen, busy, done}, 0);
        tick();

        $display("[TB] nominal pass, two windows");
        full_pass("nominal", 2, -1, 0, 1'b0, -1, 0);
`ifdef CONV_CTRL_PERF_EN
        check("nominal_busy_cycles", busy_cycles, 9);
        check("nominal_stall_cycles", stall_cycles, 0);
`endif

        $display("[TB] ofmap_full for 4 cycles on the second issue");
        full_pass("ofmap_stall", 2, 1, 4, 1'b1, -1, 0);
`ifdef CONV_CTRL_PERF_EN
        check("ofmap_stall_stall_cycles", stall_cycles, 4);
        check("ofmap_stall_busy_cycles", busy_cycles, 13);
`endif

        $display("[TB] window underflow for 3 cycles plus one drain stall");
        full_pass("underflow", 2, 3, 3, 1'b0, -1, 1);
`ifdef CONV_CTRL_PERF_EN
        check("underflow_stall_cycles", stall_cycles, 4);
        check("underflow_busy_cycles", busy_cycles, 13);
`endif

        $display("[TB] start pulsed while in READ");
        full_pass("start_busy", 2, -1, 0, 1'b0, 2, 0);

        $display("[TB] single-window pass");
        full_pass("single", 1, -1, 0, 1'b0, -1, 0);

        $display("[TB] reset during DRAIN");
        d0 = done_cnt;
        do_start();
        run_read(1, -1, 0, 1'b0, -1);
        cycle_drain(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midpass_reset_outputs", {clr_addr, read_data, stall, valid_end, acc_clr, ofmap_wen, busy, done}, 0);
`ifdef CONV_CTRL_PERF_EN
        check("midpass_reset_counters", {stall_cycles, busy_cycles}, 0);
`endif
        tick();
        tick();
        wen_q.delete();
        clr_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("midpass_reset_no_done", done_cnt - d0, 0);
        check("after_reset_busy", busy, 0);
        tick();
        full_pass("after_reset", 1, -1, 0, 1'b0, -1, 0);

        check("acc_clr_pending_end", clr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
